axi4_stream_skid: RTL
=====================

// Module: axi4_stream_skid
// PURPOSE
// - Backward-path register slice (skid buffer) for axi4_stream_if: registers TREADY
//   (the reverse direction of the stream) as well as the payload and TVALID.
// - Breaks long combinational TREADY chains between stream consumers and producers.
// - Sustains 1 transfer/cycle and loses no data under arbitrary backpressure.
// - Sits between a stream producer and a deep or slow consumer, for example at the
//   output of a delay line in front of a DMA/ADC/DAC stream sink.
// PARAMETERS
// - LN  1               number of cascaded skid stages (LN>=1); latency = LN cycles
// - DN  1               number of data lanes per beat (TDATA/TKEEP width in lanes)
// - DT  logic [8-1:0]   lane data type
// PORTS (clock/reset are carried by the sti interface; sto shares them)
// - sti.ACLK     input   1        clock, all logic on rising edge
// - sti.ARESETn  input   1        reset, synchronous, active-low
// - sti          axi4_stream_if.d input stream  (TDATA DN x DT, TKEEP DN, TLAST, TVALID in; TREADY out)
// - sto          axi4_stream_if.s output stream (TDATA, TKEEP, TLAST, TVALID out; TREADY in)
// BEHAVIOUR
// - Per stage: two payload registers, main (drives sto) and skid. State is one of
//   EMPTY (0 beats), BUSY (1 beat) or FULL (2 beats).
// - A transfer occurs on a port when TVALID & TREADY at a clock edge. ixf = input
//   transfer, oxf = output transfer.
// - All outputs are registered:
//   - sto.TVALID = (state != EMPTY)
//   - sti.TREADY = (state != FULL)
//   - No combinational path from sto.TREADY to sti.TREADY.
// - Transitions:
//   - EMPTY: ixf -> BUSY, main <= input.
//   - BUSY:  ixf & !oxf -> FULL, skid <= input.
//            !ixf & oxf -> EMPTY.
//            ixf & oxf  -> BUSY, main <= input.
//            Otherwise hold.
//   - FULL:  oxf -> BUSY, main <= skid. ixf is impossible because TREADY=0.
//            Otherwise hold.
// - Latency: a beat accepted at edge N is presented on sto at edge N+1 per stage
//   (LN total).
// - Throughput: 1 beat/cycle when sto.TREADY is held high.
// - Ordering: strict FIFO. TDATA, TKEEP and TLAST travel as one atomic beat and are
//   never split or merged.
// - Stability: while sto.TVALID=1 and sto.TREADY=0, the sto payload and TVALID hold
//   constant (AXI rule).
// - Reset (ARESETn=0 at an edge):
//   - state <= EMPTY in all stages.
//   - sto.TVALID=0, sti.TREADY=0, sto.TDATA/TKEEP/TLAST = '0.
//   - sti.TREADY rises on the first edge with ARESETn=1.
// - Reset mid-operation: buffered beats are discarded, not flushed. No partial beat
//   emerges after release.
// - Simultaneous ixf and oxf in BUSY: the new beat replaces main in the same cycle,
//   with no bubble.
// - sti.TVALID that drops without a transfer is legal upstream behaviour and has no
//   effect on state.
// STRUCTURE
// - Shared package axi4_stream_pkg: typedef skid_state_t enum {EMPTY, BUSY, FULL}
//   (2-bit).
// - Sub-module axi4_stream_skid_stg: one stage, a single state machine plus main and
//   skid registers.
// - Top: generate loop of LN stages chained through an internal
//   axi4_stream_if str[LN:0] array, sharing sti.ACLK/ARESETn.
// - No additional sub-modules; every stage uses the same axi4_stream_if modports.
// TESTING
// - Free flow, LN=1, DT=8b: sto.TREADY=1, input 0x01..0x10 back-to-back
//   -> output 0x01..0x10 one cycle later, 16 consecutive beats, no bubbles.
// - Stall: source continuous, sto.TREADY=0 for 5 cycles then 1
//   -> state goes FULL, sti.TREADY=0 for 4 cycles, beats emerge in order, none
//   lost or duplicated.
// - Alternate stall, sto.TREADY toggling 1,0,1,0 with random TVALID over 1000 beats
//   -> scoreboard matches, TLAST/TKEEP aligned, sto payload stable while stalled.
// - Reset mid-stream: 2 beats buffered (FULL), ARESETn=0 for 1 cycle
//   -> next edge TVALID=0/TREADY=0, then TREADY=1, the old beats never appear.
// - Cascade LN=3, DN=4: single beat TDATA=0xDEADBEEF, TKEEP=4'b0111, TLAST=1
//   -> appears on sto exactly 3 cycles later, unchanged.
// - Timing check: formal/lint assertion that sti.TREADY has no combinational
//   dependence on sto.TREADY.

Source files
------------

// File: rtl/axi4_stream_pkg.sv
// Shared definitions for the AXI4-Stream register slices.
package axi4_stream_pkg;

  // Occupancy of one skid stage: nothing, one beat in main, or main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle. Clock and reset travel with the interface so that a slice
// can be dropped into a stream without extra wiring.
interface axi4_stream_if #(
  parameter int unsigned DN = 1,
  parameter type         DT = logic [8-1:0]
) (
  input logic ACLK,
  input logic ARESETn
);

  logic           TVALID;
  logic           TREADY;
  DT [DN-1:0]     TDATA;
  logic [DN-1:0]  TKEEP;
  logic           TLAST;

  // Drain side: consumes beats (payload and TVALID in, TREADY out).
  modport d (
    input  ACLK, ARESETn,
    input  TVALID, TDATA, TKEEP, TLAST,
    output TREADY
  );

  // Source side: produces beats (payload and TVALID out, TREADY in).
  modport s (
    input  ACLK, ARESETn,
    output TVALID, TDATA, TKEEP, TLAST,
    input  TREADY
  );

endinterface

// File: rtl/axi4_stream_skid_stg.sv
// One skid stage: a main register driving sto and a skid register that catches
// the beat accepted in the cycle the consumer stalls. TVALID and TREADY are both
// flops, so sto.TREADY never reaches sti.TREADY combinationally.
module axi4_stream_skid_stg
  import axi4_stream_pkg::*;
#(
  parameter int unsigned DN = 1,
  parameter type         DT = logic [8-1:0]
) (
  axi4_stream_if.d sti,
  axi4_stream_if.s sto
);

  skid_state_t    r_state;
  skid_state_t    w_state_nxt;

  logic           w_ixf;
  logic           w_oxf;
  logic           w_load_main_in;
  logic           w_load_main_skid;
  logic           w_load_skid;

  logic           r_out_valid;
  logic           r_in_ready;

  DT [DN-1:0]     r_main_data;
  logic [DN-1:0]  r_main_keep;
  logic           r_main_last;
  DT [DN-1:0]     r_skid_data;
  logic [DN-1:0]  r_skid_keep;
  logic           r_skid_last;

  // Handshakes are built from our own registered flags, never from the far side.
  assign w_ixf = sti.TVALID & r_in_ready;
  assign w_oxf = r_out_valid & sto.TREADY;

  // Next-state decode and register load enables.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_ixf) begin
          w_state_nxt    = BUSY;
          w_load_main_in = 1'b1;
        end
      end
      BUSY: begin
        if (w_ixf && !w_oxf) begin
          w_state_nxt = FULL;
          w_load_skid = 1'b1;
        end else if (!w_ixf && w_oxf) begin
          w_state_nxt = EMPTY;
        end else if (w_ixf && w_oxf) begin
          // Consumer takes main while the producer refills it: no bubble.
          w_load_main_in = 1'b1;
        end
      end
      FULL: begin
        // TREADY is low here, so only the output side can move.
        if (w_oxf) begin
          w_state_nxt      = BUSY;
          w_load_main_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
  end

  // State and registered handshake flags; flags are decoded from the next state
  // so they line up with r_state on every cycle.
  always_ff @(posedge sti.ACLK) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (!sti.ARESETn) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt != EMPTY);
      r_in_ready  <= (w_state_nxt != FULL);
    end
  end

  // Main register: visible on sto, so it is cleared by reset.
  always_ff @(posedge sti.ACLK) begin
    if (!sti.ARESETn) begin
      r_main_data <= '0;
      r_main_keep <= '0;
      r_main_last <= 1'b0;
    end else if (w_load_main_in) begin
      r_main_data <= sti.TDATA;
      r_main_keep <= sti.TKEEP;
      r_main_last <= sti.TLAST;
    end else if (w_load_main_skid) begin
      r_main_data <= r_skid_data;
      r_main_keep <= r_skid_keep;
      r_main_last <= r_skid_last;
    end
  end

  // Skid register: captures the beat arriving while the consumer stalls.
  always_ff @(posedge sti.ACLK) begin
    // NOTE: no reset here; skid is only read in FULL, which it always enters
    // after being written, so clearing it would buy nothing.
    if (w_load_skid) begin
      r_skid_data <= sti.TDATA;
      r_skid_keep <= sti.TKEEP;
      r_skid_last <= sti.TLAST;
    end
  end

  assign sti.TREADY = r_in_ready;
  assign sto.TVALID = r_out_valid;
  assign sto.TDATA  = r_main_data;
  assign sto.TKEEP  = r_main_keep;
  assign sto.TLAST  = r_main_last;

endmodule

// File: rtl/axi4_stream_skid.sv
// Backward-path register slice: LN cascaded skid stages. Payload, TVALID and
// TREADY are all registered in every stage; latency is LN cycles and throughput
// stays at one beat per cycle.
module axi4_stream_skid
  import axi4_stream_pkg::*;
#(
  parameter int unsigned LN = 1,
  parameter int unsigned DN = 1,
  parameter type         DT = logic [8-1:0]
) (
  axi4_stream_if.d sti,
  axi4_stream_if.s sto
);

  // Internal links: str[0] mirrors sti, str[LN] mirrors sto.
  axi4_stream_if #(.DN(DN), .DT(DT)) str [LN:0] (
    .ACLK    (sti.ACLK),
    .ARESETn (sti.ARESETn)
  );

  assign str[0].TVALID  = sti.TVALID;
  assign str[0].TDATA   = sti.TDATA;
  assign str[0].TKEEP   = sti.TKEEP;
  assign str[0].TLAST   = sti.TLAST;
  assign sti.TREADY     = str[0].TREADY;

  assign sto.TVALID     = str[LN].TVALID;
  assign sto.TDATA      = str[LN].TDATA;
  assign sto.TKEEP      = str[LN].TKEEP;
  assign sto.TLAST      = str[LN].TLAST;
  assign str[LN].TREADY = sto.TREADY;

  for (genvar l = 0; l < LN; l++) begin : g_stg
    axi4_stream_skid_stg #(.DN(DN), .DT(DT)) u_stg (
      .sti (str[l]),
      .sto (str[l+1])
    );
  end

endmodule
